// File: rtl/hazard_forward_unit.sv
// Operand-forwarding select and load-use stall generator for the ID stage.
// Define HAZ_FORWARD_EN to enable forwarding; otherwise hazards are resolved purely by stalling.
module hazard_forward_unit #(
   parameter int REG_W  = 4,
   parameter int PC_REG = 15
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             id_valid,
   input  logic [REG_W-1:0] id_rn,
   input  logic [REG_W-1:0] id_rm,
   input  logic [REG_W-1:0] id_rd,
   input  logic             id_use_rn,
   input  logic             id_use_rm,
   input  logic             id_use_rd,
   input  logic             id_we,
   input  logic             id_load,
   input  logic             flush,
   output logic [1:0]       sel_rn,
   output logic [1:0]       sel_rm,
   output logic [1:0]       sel_rd,
   output logic             stall
);

   logic [REG_W-1:0] ex_dst_q, ex_dst_d, mem_dst_q, wb_dst_q;
   logic             ex_we_q, ex_we_d, mem_we_q, wb_we_q;
   logic             bubble;

   logic [2:0][REG_W-1:0] src;
   logic [2:0]            use_src;
   logic [2:0]            hit_ex, hit_mem, hit_wb;
   logic [2:0][1:0]       sel_vec;

   assign src     = {id_rd, id_rm, id_rn};
   assign use_src = {id_use_rd, id_use_rm, id_use_rn};

   // Index 0 = Rn, 1 = Rm, 2 = Rd (store data). The PC is always read from the register file.
   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_src
         logic live;
         assign live        = use_src[gi] && (src[gi] != REG_W'(PC_REG));
         assign hit_ex[gi]  = live && ex_we_q  && (ex_dst_q  == src[gi]);
         assign hit_mem[gi] = live && mem_we_q && (mem_dst_q == src[gi]);
         assign hit_wb[gi]  = live && wb_we_q  && (wb_dst_q  == src[gi]);
`ifdef HAZ_FORWARD_EN
         always_comb begin
            sel_vec[gi] = 2'b00;
            if (hit_ex[gi])       sel_vec[gi] = 2'b01;
            else if (hit_mem[gi]) sel_vec[gi] = 2'b10;
            else if (hit_wb[gi])  sel_vec[gi] = 2'b11;
         end
`else
         assign sel_vec[gi] = 2'b00;
`endif
      end
   endgenerate

   assign sel_rn = sel_vec[0];
   assign sel_rm = sel_vec[1];
   assign sel_rd = sel_vec[2];

`ifdef HAZ_FORWARD_EN
   // Load data only becomes forwardable from MEM, so only the EX stage needs a load bit.
   logic ex_load_q, ex_load_d;
   assign stall = id_valid && !flush && ex_load_q && (|hit_ex);
`else
   assign stall = id_valid && !flush && (|(hit_ex | hit_mem | hit_wb));
`endif

   assign bubble = stall || flush || !id_valid;

   always_comb begin
      ex_dst_d  = id_rd;
      ex_we_d   = bubble ? 1'b0 : id_we;
`ifdef HAZ_FORWARD_EN
      ex_load_d = bubble ? 1'b0 : id_load;
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ex_dst_q  <= '0;
         mem_dst_q <= '0;
         wb_dst_q  <= '0;
         ex_we_q   <= 1'b0;
         mem_we_q  <= 1'b0;
         wb_we_q   <= 1'b0;
`ifdef HAZ_FORWARD_EN
         ex_load_q <= 1'b0;
`endif
      end else begin
         ex_dst_q  <= ex_dst_d;
         mem_dst_q <= ex_dst_q;
         wb_dst_q  <= mem_dst_q;
         ex_we_q   <= ex_we_d;
         mem_we_q  <= ex_we_q;
         wb_we_q   <= mem_we_q;
`ifdef HAZ_FORWARD_EN
         ex_load_q <= ex_load_d;
`endif
      end
   end

`ifndef HAZ_FORWARD_EN
   // Load flag only matters when forwarding; without it every hazard stalls regardless.
   logic unused_load;
   assign unused_load = id_load;
   logic unused_sink;
   always_ff @(posedge clk) begin
      if (reset) unused_sink <= 1'b0;
      else       unused_sink <= unused_load & unused_sink;
   end
`endif

endmodule
